// File: rtl/trace_pkt_sink_pkg.sv
// Shared trace types: the incoming multi-lane retire packet and the per-lane record
// that trace_pkt_sink stores.
package trace_pkt_sink_pkg;

  localparam int unsigned LANES   = 3;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned ECAUSEW = 5;
  localparam int unsigned RECW    = 2 * XLEN + 2 + ECAUSEW + XLEN;

  typedef struct packed {
    logic [LANES-1:0]      valid;
    logic [LANES*XLEN-1:0] insn;
    logic [LANES*XLEN-1:0] address;
    logic [LANES-1:0]      exception;
    logic [ECAUSEW-1:0]    ecause;
    logic [LANES-1:0]      interrupt;
    logic [XLEN-1:0]       tval;
  } trace_pkt_t;

  typedef struct packed {
    logic [XLEN-1:0]    addr;
    logic [XLEN-1:0]    insn;
    logic               exc;
    logic               intr;
    logic [ECAUSEW-1:0] ecause;
    logic [XLEN-1:0]    tval;
  } trace_rec_t;

  // Number of retiring lanes in a packet.
  function automatic logic [1:0] lane_count(input logic [LANES-1:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

endpackage

// File: rtl/trace_rec_fifo.sv
// Record FIFO: up to three writes per cycle from a compacted write vector,
// one read per cycle, pointers wrap modulo DEPTH.
module trace_rec_fifo
  import trace_pkt_sink_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     wr_num,
  input  trace_rec_t [LANES-1:0]         wr_data,
  input  logic                           rd_en,
  output logic                           out_valid,
  output trace_rec_t                     rd_data,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  trace_rec_t        mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              pop;
  logic [CW-1:0]     count_nxt;

  assign pop       = rd_en & out_valid;
  assign count_nxt = count + CW'(wr_num) - CW'(pop);

  // Storage is not reset; out_valid gates what the consumer sees.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(LANES); i++) begin
      if (2'(i) < wr_num) begin
        mem[wr_ptr + AW'(i)] <= wr_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + AW'(wr_num);
      rd_ptr    <= rd_ptr + AW'(pop);
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
    end
  end

  assign rd_data = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/trace_pkt_sink.sv
// Captures multi-lane retire trace packets into a record FIFO; whole packets are
// dropped when space is short, with a sticky overflow flag and saturating drop count.
module trace_pkt_sink
  import trace_pkt_sink_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNTW  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trace_en,
  input  logic               clr,
  input  logic [2:0]         trace_rv_i_valid_ip,
  input  logic [95:0]        trace_rv_i_insn_ip,
  input  logic [95:0]        trace_rv_i_address_ip,
  input  logic [2:0]         trace_rv_i_exception_ip,
  input  logic [4:0]         trace_rv_i_ecause_ip,
  input  logic [2:0]         trace_rv_i_interrupt_ip,
  input  logic [31:0]        trace_rv_i_tval_ip,
  output logic               out_valid,
  input  logic               out_ready,
  output trace_rec_t         out_rec,
  output logic               overflow,
  output logic [CNTW-1:0]    drop_cnt
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  trace_pkt_t               pkt;
  trace_rec_t [LANES-1:0]   lane_rec;
  trace_rec_t [LANES-1:0]   cmp_rec;
  logic [1:0]               n_rec;
  logic [CW-1:0]            count;
  logic [CW-1:0]            free;
  logic                     pkt_seen;
  logic                     accept;
  logic                     drop;
  logic [1:0]               wr_num;

  assign pkt = '{valid:     trace_rv_i_valid_ip,
                 insn:      trace_rv_i_insn_ip,
                 address:   trace_rv_i_address_ip,
                 exception: trace_rv_i_exception_ip,
                 ecause:    trace_rv_i_ecause_ip,
                 interrupt: trace_rv_i_interrupt_ip,
                 tval:      trace_rv_i_tval_ip};

  // Per-lane records; cause and tval only travel with an exception or interrupt.
  always_comb begin
    lane_rec = '0;
    for (int n = 0; n < int'(LANES); n++) begin
      lane_rec[n].addr = pkt.address[32*n +: 32];
      lane_rec[n].insn = pkt.insn[32*n +: 32];
      lane_rec[n].exc  = pkt.exception[n];
      lane_rec[n].intr = pkt.interrupt[n];
      if (pkt.exception[n] || pkt.interrupt[n]) begin
        lane_rec[n].ecause = pkt.ecause;
        lane_rec[n].tval   = pkt.tval;
      end
    end
  end

  // Pack valid lanes downward in ascending lane order.
  always_comb begin
    logic [1:0] idx;
    cmp_rec = '0;
    idx     = '0;
    for (int n = 0; n < int'(LANES); n++) begin
      if (pkt.valid[n]) begin
        cmp_rec[idx] = lane_rec[n];
        idx          = idx + 2'd1;
      end
    end
  end

  // Space check uses the count at the start of the cycle, ignoring this cycle's pop.
  assign n_rec    = lane_count(pkt.valid);
  assign free     = CW'(DEPTH) - count;
  assign pkt_seen = trace_en & (|pkt.valid);
  assign accept   = pkt_seen & (free >= CW'(n_rec));
  assign drop     = pkt_seen & ~accept;
  assign wr_num   = accept ? n_rec : 2'd0;

  trace_rec_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_num   (wr_num),
    .wr_data  (cmp_rec),
    .rd_en    (out_ready),
    .out_valid(out_valid),
    .rd_data  (out_rec),
    .count    (count)
  );

  // Drop bookkeeping; clr wins over a drop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: doc/trace_pkt_sink.md
TRACE_PKT_SINK -- requirements
Module: trace_pkt_sink

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of record FIFO entries; power of two, 4..32.
REQ-002 SHALL have parameter CNTW, default 16, meaning width of the drop counter.
REQ-003 SHALL have port clk  input  1  the single clock.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port trace_en  input  1  capture enable.
REQ-006 SHALL have port clr  input  1  clears the overflow flag and the drop counter.
REQ-007 SHALL have port trace_rv_i_valid_ip  input  3  per-lane instruction retire valid.
REQ-008 SHALL have port trace_rv_i_insn_ip  input  96  lane n instruction at [32n+31:32n].
REQ-009 SHALL have port trace_rv_i_address_ip  input  96  lane n PC at [32n+31:32n].
REQ-010 SHALL have port trace_rv_i_exception_ip  input  3  per-lane exception.
REQ-011 SHALL have port trace_rv_i_ecause_ip  input  5  cause, shared across lanes.
REQ-012 SHALL have port trace_rv_i_interrupt_ip  input  3  per-lane interrupt.
REQ-013 SHALL have port trace_rv_i_tval_ip  input  32  tval, shared across lanes.
REQ-014 SHALL have port out_valid  output  1  a record is available.
REQ-015 SHALL have port out_ready  input  1  consumer accepts the record.
REQ-016 SHALL have port out_rec  output  103  record {addr[31:0], insn[31:0], exc, intr, ecause[4:0], tval[31:0]}, MSB first.
REQ-017 SHALL have port overflow  output  1  sticky packet-drop flag.
REQ-018 SHALL have port drop_cnt  output  CNTW  count of dropped packets.

Function
REQ-019 SHALL treat a cycle with trace_en=1 and nonzero valid_ip as one packet of N = popcount(valid_ip) records.
REQ-020 SHALL build lane n's record from lane n slices of the vectors.
- ecause and tval are taken from the shared inputs when lane n's exc or intr bit is set; otherwise they are zero.
REQ-021 SHALL accept a packet only if free entries at the start of the cycle, excluding that cycle's pop, are >= N.
- An accepted packet writes its records in ascending lane order, skipping invalid lanes, in the same cycle.
REQ-022 SHALL drop the whole packet (no partial write) when space is insufficient.
- overflow is set to 1 on the next edge.
- drop_cnt increments by 1 and saturates at all-ones.
REQ-023 SHALL present the FIFO head on out_rec with out_valid=1 whenever the FIFO is nonempty.
- Pop occurs on a cycle with out_valid & out_ready.
- out_rec is held stable while out_valid=1 and out_ready=0.
REQ-024 SHALL support push and pop in the same cycle; the count updates by N minus the pop.
REQ-025 SHALL have first-write to out_valid latency of one cycle.
- Records written at edge k are visible as out_valid=1 after edge k.
- There is no write-through bypass.
REQ-026 SHALL wrap read and write pointers modulo DEPTH.
- Full is count==DEPTH; empty is count==0.
REQ-027 SHALL give clr=1 priority over a simultaneous drop.
- overflow goes to 0 and drop_cnt goes to 0.
- FIFO contents are unaffected.
REQ-028 SHALL ignore valid_ip entirely when trace_en=0: no push and no drop.
- Pops continue while trace_en=0.

Reset
REQ-029 SHALL, on rst=1 at a clk edge, empty the FIFO (pointers and count = 0).
- out_valid, overflow and drop_cnt become 0.
- The packet presented in the reset cycle is discarded.
- out_rec is zero while empty.
REQ-030 SHALL give reset priority over clr, push and pop; FIFO storage arrays need no reset.

Structure
REQ-031 SHALL place the trace record typedef (trace_rec_t, 103 bits) in the shared types package, next to the existing trace packet struct.
REQ-032 SHALL implement the storage as one sub-module, trace_rec_fifo.
- Multi-write (0..3 per cycle), single-read.
- Parameterised by DEPTH.
- Lane compaction and drop logic stay in trace_pkt_sink.

Verification
REQ-033 SHALL cover lane compaction: valid_ip=3'b101 with lane0 addr 0x100, lane2 addr 0x108.
- Two records pop in order 0x100 then 0x108.
REQ-034 SHALL cover exception attach: valid_ip=3'b011, exception_ip=3'b010, ecause=5'd2, tval=0xDEADBEEF.
- Lane0 record has ecause=0, tval=0.
- Lane1 record has exc=1, ecause=2, tval=0xDEADBEEF.
REQ-035 SHALL cover overflow: DEPTH=8, fill 7 with out_ready=0, then send valid_ip=3'b011.
- Packet is dropped and count stays 7.
- overflow=1, drop_cnt=1.
- A following valid_ip=3'b001 is accepted (count 8).
REQ-036 SHALL cover full with simultaneous pop: count=8, out_ready=1, valid_ip=3'b001.
- Packet is dropped (free=0 before pop).
- Count becomes 7.
REQ-037 SHALL cover wrap-around: stream 40 single-lane packets with out_ready=1 every cycle.
- All 40 records emerge in order; drop_cnt=0.
REQ-038 SHALL cover reset mid-operation: count=5, assert rst for one cycle concurrent with valid_ip=3'b111.
- Afterwards out_valid=0, count=0, overflow=0.
